// File: rtl/inv_key_expansion_gen_if.sv
// Handshake/bus bundle between the inverse AES-128 key scheduler and its consumer.
// Signals:
//   start     - request a new schedule run (consumer -> scheduler)
//   last_key  - round-10 key, bit 0 = MSB of byte 0 (consumer -> scheduler)
//   key_ready - consumer accepts round_key this cycle (consumer -> scheduler)
//   round_key - current round key, same bit ordering as last_key (scheduler -> consumer)
//   round_idx - round number of round_key, 10 down to 0 (scheduler -> consumer)
//   key_valid - round_key/round_idx valid (scheduler -> consumer)
//   busy      - run in progress (scheduler -> consumer)
//   done      - one-cycle pulse after round 0 is accepted (scheduler -> consumer)
interface inv_key_expansion_gen_if;

  logic           start;
  logic [0:127]   last_key;
  logic           key_ready;
  logic [0:127]   round_key;
  logic [3:0]     round_idx;
  logic           key_valid;
  logic           busy;
  logic           done;

  // Consumer side: drives requests and the accept strobe.
  modport master (
    output start,
    output last_key,
    output key_ready,
    input  round_key,
    input  round_idx,
    input  key_valid,
    input  busy,
    input  done
  );

  // Scheduler side.
  modport slave (
    input  start,
    input  last_key,
    input  key_ready,
    output round_key,
    output round_idx,
    output key_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/inv_key_expansion_gen.sv
// Inverse AES-128 key scheduler: from the round-10 key, regenerates round keys
// 10 down to 0, one per accepted beat, in the order the inverse cipher uses them.
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - synchronous active-high reset, dominates every other input
//   kx    - slave side of inv_key_expansion_gen_if (start/last_key/key_ready in,
//           round_key/round_idx/key_valid/busy/done out)
module inv_key_expansion_gen (
  input  logic                    clk,
  input  logic                    reset,
  inv_key_expansion_gen_if.slave  kx
);

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 4;

  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(10);

  // Forward AES S-box, entry n at bits [8n +: 8] (MSB first).
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Byte substitution through the forward S-box.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{b, 3'b000} +: 8];
  endfunction

  // Round constant used when producing round r-1 from round r.
  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    unique case (r)
      IDX_W'(1):  rc = 8'h01;
      IDX_W'(2):  rc = 8'h02;
      IDX_W'(3):  rc = 8'h04;
      IDX_W'(4):  rc = 8'h08;
      IDX_W'(5):  rc = 8'h10;
      IDX_W'(6):  rc = 8'h20;
      IDX_W'(7):  rc = 8'h40;
      IDX_W'(8):  rc = 8'h80;
      IDX_W'(9):  rc = 8'h1b;
      IDX_W'(10): rc = 8'h36;
      default:    rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_e              state_q, state_d;
  logic [0:KEY_W-1]    key_q, key_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                done_q, done_d;

  logic [0:WORD_W-1]   w0, w1, w2, w3;
  logic [0:WORD_W-1]   p0, p1, p2, p3;
  logic [0:WORD_W-1]   rot_p3, sub_rot_p3;
  logic [0:KEY_W-1]    prev_key;
  logic                accept;
  logic                last_beat;

  // Inverse key-schedule step: round r words -> round r-1 words.
  always_comb begin
    w0 = key_q[0:31];
    w1 = key_q[32:63];
    w2 = key_q[64:95];
    w3 = key_q[96:127];
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    // p3 equals forward w[i-1] for the first word, so RotWord/SubWord apply to it.
    rot_p3     = {p3[8:31], p3[0:7]};
    sub_rot_p3 = {sbox(rot_p3[0:7]),   sbox(rot_p3[8:15]),
                  sbox(rot_p3[16:23]), sbox(rot_p3[24:31])};
    p0 = w0 ^ sub_rot_p3 ^ {rcon(idx_q), 24'h000000};
    prev_key = {p0, p1, p2, p3};
  end

  assign accept    = (state_q == ST_RUN) && kx.key_ready;
  assign last_beat = (idx_q == '0);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (kx.start)            state_d = ST_RUN;
      ST_RUN:  if (accept && last_beat) state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    key_d  = key_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (kx.start) begin
          key_d = kx.last_key;
          idx_d = LAST_ROUND;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (last_beat) begin
            // Round-0 key stays visible until the next start.
            done_d = 1'b1;
          end else begin
            key_d = prev_key;
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign kx.round_key = key_q;
  assign kx.round_idx = idx_q;
  assign kx.key_valid = (state_q == ST_RUN);
  assign kx.busy      = (state_q == ST_RUN);
  assign kx.done      = done_q;

endmodule

// File: tb/tb_inv_key_expansion_gen.sv
// Scoreboard bench for inv_key_expansion_gen: the driver pushes the expected
// round keys when a start is issued, a monitor pops and compares on each
// accepted beat and checks done pulses and stability under backpressure.
module tb_inv_key_expansion_gen;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  localparam logic [127:0] STALL_RK [0:10] = '{
    128'h0f1571c947d9e8590cb7add6af7f6798,
    128'hdc9037b09b49dfe997fe723f388115a7,
    128'hd2c96bb74980b45ede7ec661e6ffd3c6,
    128'hc0afdf39892f6b675751ad06b1ae7ec0,
    128'h2c5c65f1a5730e96f222a390438cdd50,
    128'h589d36ebfdee387d0fcc9bed4c4046bd,
    128'h71c74cc28c2974bf83e5ef52cfa5a9ef,
    128'h37149348bb3de7f738d808a5f77da14a,
    128'h48264520f31ba2d7cbc3aa723cbe0b38,
    128'hfd0d42cb0e16e01cc5d54a6ef96b4156,
    128'hb48ef352ba98134e7f4d592086261876
  };

  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  inv_key_expansion_gen_if bus ();

  inv_key_expansion_gen dut (
    .clk   (clk),
    .reset (reset),
    .kx    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Push the 11 expected beats of a run, round 10 first.
  task automatic push_run(input bit use_fips);
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.idx = 4'(r);
      e.key = use_fips ? FIPS_RK[r] : STALL_RK[r];
      sb_q.push_back(e);
    end
  endtask

  // Issue a start pulse; the edge that samples it is the second posedge here.
  task automatic do_start(input bit use_fips);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.last_key = use_fips ? FIPS_RK[10] : STALL_RK[10];
    push_run(use_fips);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.last_key = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Count cycles until done is seen; optional random backpressure and a
  // stray start pulse (different key) while busy. Returns at the done negedge.
  task automatic wait_done(input bit bp, input bit inj, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_start", 128'(bus.busy), 128'd1);
      if (bus.done === 1'b1) begin
        check("busy_at_done", 128'(bus.busy), 128'd0);
        break;
      end
      if (n >= 400) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        break;
      end
      @(posedge clk); #1;
      if (bp) bus.key_ready = 1'($urandom_range(0, 1));
      if (inj && n == 3) begin
        bus.start    = 1'b1;
        bus.last_key = {$urandom, $urandom, $urandom, $urandom};
      end
      if (inj && n == 5) bus.start = 1'b0;
    end
  endtask

  // Scoreboard monitor: compares every accepted beat and checks done/hold.
  task automatic monitor();
    logic         expect_done = 1'b0;
    logic         prev_hold   = 1'b0;
    logic [127:0] pk = '0;
    logic [3:0]   pi = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (expect_done) begin
        check("done_pulse", 128'(bus.done), 128'd1);
        expect_done = 1'b0;
      end else begin
        check("no_done", 128'(bus.done), 128'd0);
      end
      if (prev_hold) begin
        check("hold_valid", 128'(bus.key_valid), 128'd1);
        check("hold_key", bus.round_key, pk);
        check("hold_idx", 128'(bus.round_idx), 128'(pi));
      end
      if (bus.key_valid === 1'b1 && bus.key_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got idx %0d key %h expected no beat",
                   bus.round_idx, bus.round_key);
        end else begin
          e = sb_q.pop_front();
          check("beat_idx", 128'(bus.round_idx), 128'(e.idx));
          check("beat_key", bus.round_key, e.key);
          if (e.idx == 4'd0) expect_done = 1'b1;
        end
      end
      prev_hold = (bus.key_valid === 1'b1) && (bus.key_ready === 1'b0);
      pk = bus.round_key;
      pi = bus.round_idx;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_round_key"}, bus.round_key, 128'd0);
    check({tag, "_round_idx"}, 128'(bus.round_idx), 128'd0);
    check({tag, "_key_valid"}, 128'(bus.key_valid), 128'd0);
    check({tag, "_busy"}, 128'(bus.busy), 128'd0);
    check({tag, "_done"}, 128'(bus.done), 128'd0);
  endtask

  initial begin
    int  n;
    bit  found;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.last_key  = '0;
    bus.key_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    fork
      monitor();
    join_none

    // Stallings vector, key_ready held high: done 12 cycles after start edge.
    do_start(1'b0);
    wait_done(1'b0, 1'b0, n);
    check("stall_latency", 128'(n), 128'd12);
    check("stall_round0_held", bus.round_key, STALL_RK[0]);

    // Back-to-back: start during the done cycle with the FIPS-197 key.
    bus.start    = 1'b1;
    bus.last_key = FIPS_RK[10];
    push_run(1'b1);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.last_key = '0;
    @(negedge clk);
    check("b2b_valid", 128'(bus.key_valid), 128'd1);
    check("b2b_idx", 128'(bus.round_idx), 128'd10);
    check("b2b_key", bus.round_key, FIPS_RK[10]);
    wait_done(1'b0, 1'b0, n);
    check("b2b_latency", 128'(n), 128'd11);
    check("fips_round0_held", bus.round_key, FIPS_RK[0]);
    check("fips_queue_empty", 128'(sb_q.size()), 128'd0);

    // Ignored start while busy: sequence must be unchanged.
    do_start(1'b0);
    wait_done(1'b0, 1'b1, n);
    check("ignored_start_latency", 128'(n), 128'd12);
    check("ignored_start_queue_empty", 128'(sb_q.size()), 128'd0);

    // Random backpressure on key_ready.
    do_start(1'b1);
    wait_done(1'b1, 1'b0, n);
    bus.key_ready = 1'b1;
    check("bp_queue_empty", 128'(sb_q.size()), 128'd0);
    repeat (3) @(posedge clk);

    // Reset mid-run at round 5.
    do_start(1'b0);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.key_valid === 1'b1 && bus.round_idx == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_round5", 128'(found), 128'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    sb_q.delete();
    @(negedge clk);
    check_zero_outputs("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (14) @(negedge clk);

    // Full run after the abort.
    do_start(1'b0);
    wait_done(1'b0, 1'b0, n);
    check("post_reset_latency", 128'(n), 128'd12);
    check("post_reset_queue_empty", 128'(sb_q.size()), 128'd0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_key_expansion_gen.md
Name: inv_key_expansion_gen

Overview:
- Inverse AES-128 key scheduler for the decryption datapath.
- Takes the final (round-10) round key and regenerates round keys 10 down to 0, one per cycle, in the order the inverse cipher consumes them.
- It is the backward counterpart of keyExpansionGen. Instead of storing all 1408 bits of expanded key, decryption needs only this block plus the round-10 key.

Parameters:
- None. AES-128 only: Nk=4, Nr=10.

Ports:
- clk        input   1    system clock; all state updates on rising edge
- reset      input   1    synchronous, active-high reset
- start      input   1    request a new schedule run; sampled only when busy=0
- last_key   input   [0:127]  round-10 key (w[40..43]); bit 0 = MSB of byte 0; w[40]=last_key[0:31]
- key_ready  input   1    consumer accepts round_key this cycle
- round_key  output  [0:127]  current round key, same bit ordering as last_key
- round_idx  output  4    round number of round_key (10 down to 0)
- key_valid  output  1    round_key/round_idx valid
- busy       output  1    run in progress
- done       output  1    one-cycle pulse after round 0 is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset; reset dominates every other input.
- Reset values: round_key=0, round_idx=0, key_valid=0, busy=0, done=0. Internal state returns to IDLE.
- IDLE (busy=0, key_valid=0):
  - On start=1, latch last_key into the key register and load round_idx=10.
  - busy=1 and key_valid=1 from the next cycle.
- RUN (busy=1, key_valid=1):
  - round_key and round_idx hold stable while key_ready=0.
  - On key_valid & key_ready with round_idx>0, update the key register to the previous round key and decrement round_idx. key_valid stays 1.
  - On key_valid & key_ready with round_idx=0:
    - key_valid=0, busy=0, done=1 for exactly one cycle.
    - round_key keeps the round-0 value until the next start.
- Inverse step, from round r key words w0..w3 to round r-1 key words p0..p3:
  - p3 = w3 ^ w2
  - p2 = w2 ^ w1
  - p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - Use the forward S-box: four byte instances, combinational.
  - The step is single-cycle, with no multicycle paths.
- Latency with key_ready held at 1:
  - start sampled at edge T.
  - Round 10 valid in cycle T+1, round 0 in cycle T+11.
  - done in cycle T+12.
  - Total 11 beats.
- start while busy=1 is ignored. It does not restart or reload.
- start in the same cycle as done is accepted (busy=0 then). The new run begins: key_valid=1 next cycle, round_idx=10.
- last_key is sampled only at start acceptance; later changes have no effect.
- reset asserted mid-run aborts immediately to the reset values. No done pulse is produced.
- round_idx never wraps below 0.

Test Plan:
- Stallings vector: reset, then start with last_key=b48ef352ba98134e7f4d592086261876, key_ready=1 -> beats 10..0. Round 9 = fd0d42cb0e16e01cc5d54a6ef96b4156. Round 0 = 0f1571c947d9e8590cb7add6af7f6798. Every beat matches the reversed 1408-bit keyExpansionGen expected vector. done at T+12.
- FIPS-197 vector: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> round 0 = 2b7e151628aed2a6abf7158809cf4f3c. Round 9 = ac7766f319fadc2128d12941575c006e.
- Backpressure: toggle key_ready pseudo-randomly -> round_key/round_idx stable while key_ready=0. Exactly 11 accepted beats with idx 10..0. One done pulse.
- Ignored start: pulse start with a different last_key while busy=1 -> sequence unchanged and completes normally.
- Back-to-back: assert start in the done cycle -> next cycle key_valid=1, round_idx=10, round_key = new last_key.
- Reset mid-run: assert reset at round_idx=5 -> next cycle all outputs 0 and no done. A subsequent start produces a full correct sequence.
